// File: rtl/avalon_result_responder_if.sv
// rtl/avalon_result_responder_if.sv - Avalon-MM bus between the FFT master and the result responder
interface avalon_result_responder_if #(
  parameter int ADDRESSWIDTH = 32,
  parameter int DATAWIDTH    = 32
);
  logic [ADDRESSWIDTH-1:0] avs_address;
  logic                    avs_write;
  logic [DATAWIDTH-1:0]    avs_writedata;
  logic                    avs_read;
  logic [DATAWIDTH-1:0]    avs_readdata;
  logic                    avs_readdatavalid;
  logic                    avs_waitrequest;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata, avs_readdatavalid, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata, avs_readdatavalid, avs_waitrequest
  );
endinterface

// File: rtl/avalon_result_responder.sv
// rtl/avalon_result_responder.sv - Avalon-MM slave that stalls, stores FFT results in SRAM and reports status
module avalon_result_responder #(
  parameter int                    ADDRESSWIDTH   = 32,
  parameter int                    DATAWIDTH      = 32,
  parameter int                    MEM_ADDR_BITS  = 9,
  parameter int                    MEM_DATAWIDTH  = 16,
  parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR    = 32'h0000_0000,
  parameter int                    WAIT_CYCLES    = 2,
  parameter int                    EXPECTED_WORDS = 512
) (
  input  logic                     clk,
  input  logic                     n_rst,
  avalon_result_responder_if.slave bus,
  output logic                     mem_wren,
  output logic                     mem_rden,
  output logic [MEM_ADDR_BITS-1:0] mem_address,
  output logic [MEM_DATAWIDTH-1:0] mem_data,
  input  logic [MEM_DATAWIDTH-1:0] mem_q,
  input  logic                     clear,
  output logic [MEM_ADDR_BITS:0]   word_count,
  output logic                     done,
  output logic                     err_range
);

  typedef enum logic [2:0] {IDLE, WAIT, ACCEPT, RD1, RD2} state_t;

  localparam logic [3:0]             WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [MEM_ADDR_BITS:0] COUNT_MAX = (MEM_ADDR_BITS+1)'(EXPECTED_WORDS);

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic op_write, op_write_next;
  logic op_both, op_both_next;
  logic acc_err;
  logic rd_ok;
  logic req_held;

  // Extra borrow bit catches addresses below the window without a constant compare.
  logic                    borrow;
  logic [ADDRESSWIDTH-1:0] offset;
  logic                    in_range;
  logic [MEM_ADDR_BITS-1:0] index;
  logic                    unused_bits;

  assign {borrow, offset} = {1'b0, bus.avs_address} - {1'b0, BASE_ADDR};
  assign in_range = !borrow && (offset[ADDRESSWIDTH-1:MEM_ADDR_BITS+2] == '0);
  assign index = offset[MEM_ADDR_BITS+1:2];
  assign unused_bits = ^{offset[1:0], bus.avs_writedata[DATAWIDTH-1:MEM_DATAWIDTH]};

  assign req_held = op_write ? bus.avs_write : bus.avs_read;
  assign bus.avs_waitrequest = (state != ACCEPT);
  assign done = (word_count == COUNT_MAX);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    op_write_next = op_write;
    op_both_next  = op_both;
    case (state)
      IDLE: begin
        if (bus.avs_write || bus.avs_read) begin
          op_write_next = bus.avs_write;
          op_both_next  = bus.avs_write && bus.avs_read;
          if (WAIT_CYCLES == 0) begin
            state_next = ACCEPT;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (!req_held) begin
          state_next = IDLE;
        end else if (cnt <= 4'd1) begin
          state_next = ACCEPT;
        end
      end
      ACCEPT:  state_next = op_write ? IDLE : RD1;
      RD1:     state_next = RD2;
      RD2:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      op_write              <= 1'b0;
      op_both               <= 1'b0;
      acc_err               <= 1'b0;
      rd_ok                 <= 1'b0;
      mem_wren              <= 1'b0;
      mem_rden              <= 1'b0;
      mem_address           <= '0;
      mem_data              <= '0;
      bus.avs_readdata      <= '0;
      bus.avs_readdatavalid <= 1'b0;
      word_count            <= '0;
      err_range             <= 1'b0;
    end else begin
      state                 <= state_next;
      cnt                   <= cnt_next;
      op_write              <= op_write_next;
      op_both               <= op_both_next;
      mem_wren              <= 1'b0;
      mem_rden              <= 1'b0;
      bus.avs_readdatavalid <= 1'b0;

      // SRAM strobes are set up on entry so they are high during the accept cycle itself.
      if (state_next == ACCEPT) begin
        acc_err <= op_both_next || !in_range;
        rd_ok   <= in_range;
        if (op_write_next) begin
          mem_wren <= in_range;
          if (in_range) begin
            mem_address <= index;
            mem_data    <= bus.avs_writedata[MEM_DATAWIDTH-1:0];
          end
        end else begin
          mem_rden <= in_range;
          if (in_range) begin
            mem_address <= index;
          end
        end
      end

      if (state == RD1) begin
        bus.avs_readdatavalid <= 1'b1;
        bus.avs_readdata      <= rd_ok ? {{(DATAWIDTH-MEM_DATAWIDTH){1'b0}}, mem_q} : '0;
      end

      if (clear) begin
        word_count <= '0;
        err_range  <= 1'b0;
      end else begin
        if (mem_wren && (word_count != COUNT_MAX)) begin
          word_count <= word_count + 1'b1;
        end
        if ((state == ACCEPT) && acc_err) begin
          err_range <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_result_responder.sv
// tb/tb_avalon_result_responder.sv - randomized scoreboard bench for avalon_result_responder
module tb_avalon_result_responder;

  localparam int WAIT_CYCLES = 2;
  localparam int NWORDS      = 512;

  logic        clk;
  logic        n_rst;
  logic        mem_wren, mem_rden;
  logic [8:0]  mem_address;
  logic [15:0] mem_data;
  logic [15:0] mem_q;
  logic        clear;
  logic [9:0]  word_count;
  logic        done;
  logic        err_range;

  avalon_result_responder_if #(.ADDRESSWIDTH(32), .DATAWIDTH(32)) bus ();

  avalon_result_responder dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .bus         (bus),
    .mem_wren    (mem_wren),
    .mem_rden    (mem_rden),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_q       (mem_q),
    .clear       (clear),
    .word_count  (word_count),
    .done        (done),
    .err_range   (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM with one-cycle read latency
  logic [15:0] sram [NWORDS];
  always @(posedge clk) begin
    if (mem_wren) sram[mem_address] <= mem_data;
    if (mem_rden) mem_q <= sram[mem_address];
  end

  typedef struct {
    logic [8:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [15:0] ref_mem [NWORDS];
  int          ref_count;
  bit          ref_err;
  int          errors;
  int          checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (mem_wren) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_wren", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_address", {23'd0, mem_address}, {23'd0, e.a});
          chk("wr_data", {16'd0, mem_data}, {16'd0, e.d});
        end
      end
      if (bus.avs_readdatavalid) begin
        if (exp_rd.size() == 0) begin
          chk("unexpected_rdvalid", 32'd1, 32'd0);
        end else begin
          chk("rd_data", bus.avs_readdata, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic check_status();
    chk("word_count", {22'd0, word_count}, ref_count);
    chk("err_range", {31'd0, err_range}, {31'd0, ref_err});
    chk("done", {31'd0, done}, {31'd0, ref_count == NWORDS});
  endtask

  task automatic check_reset_vals();
    chk("rst_waitrequest", {31'd0, bus.avs_waitrequest}, 32'd1);
    chk("rst_rdvalid", {31'd0, bus.avs_readdatavalid}, 32'd0);
    chk("rst_readdata", bus.avs_readdata, 32'd0);
    chk("rst_wren", {31'd0, mem_wren}, 32'd0);
    chk("rst_rden", {31'd0, mem_rden}, 32'd0);
    chk("rst_address", {23'd0, mem_address}, 32'd0);
    chk("rst_data", {16'd0, mem_data}, 32'd0);
    chk("rst_count", {22'd0, word_count}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err_range}, 32'd0);
  endtask

  task automatic xfer(input bit wr, input bit rd, input logic [31:0] addr,
                      input logic [31:0] data, input bit clr);
    int  stalls;
    int  lat;
    int  idx;
    bit  inr;
    bit  is_read;
    idx     = int'(addr >> 2);
    inr     = (addr < 32'h800);
    is_read = rd && !wr;
    if (wr) begin
      if (inr) begin
        exp_wr.push_back('{a: idx[8:0], d: data[15:0]});
        ref_mem[idx] = data[15:0];
        ref_count = (ref_count < NWORDS) ? ref_count + 1 : NWORDS;
      end else begin
        ref_err = 1'b1;
      end
      if (rd) ref_err = 1'b1;
    end else begin
      exp_rd.push_back(inr ? {16'd0, ref_mem[idx]} : 32'd0);
      if (!inr) ref_err = 1'b1;
    end
    if (clr) begin
      ref_count = 0;
      ref_err   = 1'b0;
    end

    @(posedge clk); #1;
    bus.avs_address   = addr;
    bus.avs_writedata = data;
    bus.avs_write     = wr;
    bus.avs_read      = rd;
    stalls = 0;
    while (1) begin
      @(negedge clk);
      if (!bus.avs_waitrequest) break;
      stalls++;
      if (stalls > 40) break;
    end
    chk("stall_cycles", stalls, WAIT_CYCLES + 1);
    if (is_read) chk("rden_at_accept", {31'd0, mem_rden}, {31'd0, inr});
    else         chk("wren_at_accept", {31'd0, mem_wren}, {31'd0, inr});
    if (clr) clear = 1'b1;
    @(posedge clk); #1;
    bus.avs_write = 1'b0;
    bus.avs_read  = 1'b0;
    clear         = 1'b0;
    chk("waitreq_after_accept", {31'd0, bus.avs_waitrequest}, 32'd1);
    if (is_read) begin
      lat = 0;
      while (lat < 8) begin
        @(negedge clk);
        lat++;
        if (bus.avs_readdatavalid) break;
      end
      chk("rd_latency", lat, 32'd2);
      @(negedge clk);
      chk("rdvalid_one_cycle", {31'd0, bus.avs_readdatavalid}, 32'd0);
    end else begin
      @(negedge clk);
    end
    check_status();
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    ref_count = 0;
    ref_err   = 1'b0;
    @(negedge clk);
    check_status();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    ref_count = 0;
    ref_err = 1'b0;
    for (int i = 0; i < NWORDS; i++) begin
      sram[i]    = 16'h0;
      ref_mem[i] = 16'h0;
    end
    mem_q             = 16'h0;
    clear             = 1'b0;
    bus.avs_address   = '0;
    bus.avs_writedata = '0;
    bus.avs_write     = 1'b0;
    bus.avs_read      = 1'b0;
    n_rst             = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    n_rst = 1'b1;

    xfer(1, 0, 32'h0, 32'h1234_ABCD, 0);

    pulse_clear();
    for (int i = 0; i < NWORDS; i++) begin
      xfer(1, 0, 32'(4 * i), 32'(i), 0);
    end
    xfer(1, 0, 32'h0, 32'h0000_0777, 0);

    xfer(1, 0, 32'h40, 32'h0000_55AA, 0);
    xfer(0, 1, 32'h40, 32'h0, 0);

    pulse_clear();
    xfer(1, 0, 32'h800, 32'hDEAD_BEEF, 0);
    pulse_clear();

    // Master withdraws a write while it is still being stalled
    @(posedge clk); #1;
    bus.avs_address   = 32'h10;
    bus.avs_writedata = 32'h0000_9999;
    bus.avs_write     = 1'b1;
    @(posedge clk); #1;
    bus.avs_write = 1'b0;
    repeat (4) @(negedge clk);
    chk("drop_waitrequest", {31'd0, bus.avs_waitrequest}, 32'd1);
    check_status();

    xfer(1, 1, 32'h14, 32'h0000_4321, 0);
    xfer(0, 1, 32'h14, 32'h0, 0);

    for (int n = 0; n < 120; n++) begin
      int          idx;
      bit          wr, rd;
      logic [31:0] addr;
      if ($urandom_range(0, 7) == 0) idx = 512 + int'($urandom_range(0, 300));
      else                           idx = int'($urandom_range(0, 511));
      addr = 32'(idx * 4) + 32'($urandom_range(0, 3));
      wr = ($urandom_range(0, 1) == 1);
      rd = !wr || ($urandom_range(0, 9) == 0);
      xfer(wr, rd, addr, $urandom, 0);
      if ($urandom_range(0, 19) == 0) pulse_clear();
    end
    xfer(0, 1, 32'hC00, 32'h0, 0);

    xfer(1, 0, 32'h20, 32'h0000_1111, 1);
    xfer(1, 0, 32'h24, 32'h0000_2222, 0);

    // Reset while a write sits in its stall window
    @(posedge clk); #1;
    bus.avs_address   = 32'h30;
    bus.avs_writedata = 32'h0000_3333;
    bus.avs_write     = 1'b1;
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    check_reset_vals();
    bus.avs_write = 1'b0;
    ref_count = 0;
    ref_err   = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_waitrequest", {31'd0, bus.avs_waitrequest}, 32'd1);
    check_status();
    xfer(0, 1, 32'h30, 32'h0, 0);

    chk("wr_queue_drained", exp_wr.size(), 32'd0);
    chk("rd_queue_drained", exp_rd.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
